load_align_unit: RTL and testbench

- Load-side counterpart to the address generation stage: consumes load uops carrying a byte address, access size and sign-extend flag.
- Issues a word read to the data memory port and realigns / zero- or sign-extends the returned word.
- Buffers aligned results in a small in-order FIFO until writeback accepts them.
- Drops in-flight and buffered loads younger than a mispredicted branch.

---
 rtl/load_align_unit.sv | 165 ++++++++++++++++
 tb/tb_load_align_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: issues a word read for each load uop, realigns and
// zero/sign-extends the returned word, and buffers results in order for writeback.
module load_align_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SQN_W = 6,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  output logic             IN_ready,
  input  logic [31:0]      IN_addr,
  input  logic [1:0]       IN_size,
  input  logic             IN_signExt,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [4:0]       IN_nmDst,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic             IN_branchTaken,
  input  logic [SQN_W-1:0] IN_branchSqN,
  output logic             OUT_memEn,
  output logic [29:0]      OUT_memAddr,
  input  logic [31:0]      IN_memData,
  output logic             OUT_valid,
  input  logic             IN_wbReady,
  output logic [31:0]      OUT_result,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [4:0]       OUT_nmDst,
  output logic [SQN_W-1:0] OUT_sqN
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Wrap-aware age compare: sqn is strictly younger than the branch.
  function automatic logic younger(input logic [SQN_W-1:0] sqn,
                                   input logic [SQN_W-1:0] br);
    logic [SQN_W-1:0] d;
    d = sqn - br;
    return (d != '0) && !d[SQN_W-1];
  endfunction

  // S1 stage
  logic             s1_valid;
  logic [29:0]      s1_waddr;
  logic [1:0]       s1_low;
  logic [1:0]       s1_size;
  logic             s1_sext;
  logic [TAG_W-1:0] s1_tag;
  logic [4:0]       s1_nm;
  logic [SQN_W-1:0] s1_sqn;

  // S2 stage
  logic             s2_valid;
  logic [1:0]       s2_low;
  logic [1:0]       s2_size;
  logic             s2_sext;
  logic [TAG_W-1:0] s2_tag;
  logic [4:0]       s2_nm;
  logic [SQN_W-1:0] s2_sqn;

  // Result FIFO
  logic [31:0]      f_result [DEPTH];
  logic [TAG_W-1:0] f_tag    [DEPTH];
  logic [4:0]       f_nm     [DEPTH];
  logic [SQN_W-1:0] f_sqn    [DEPTH];
  logic [DEPTH-1:0] f_dead;
  logic [AW:0]      rd_ptr, wr_ptr;

  logic [AW-1:0] rd_idx, wr_idx;
  logic [AW:0]   count;
  logic [AW+1:0] occ;
  logic          empty, accept, in_kill, s1_kill, s2_kill, head_kill;
  logic          push, pop;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   aligned;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign occ    = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);

  assign IN_ready  = occ < (AW+2)'(DEPTH);
  assign accept    = IN_valid && IN_ready;
  assign in_kill   = IN_branchTaken && younger(IN_sqN, IN_branchSqN);
  assign s1_kill   = IN_branchTaken && younger(s1_sqn, IN_branchSqN);
  assign s2_kill   = IN_branchTaken && younger(s2_sqn, IN_branchSqN);
  assign head_kill = IN_branchTaken && younger(f_sqn[rd_idx], IN_branchSqN);

  assign OUT_memEn   = s1_valid && !s1_kill;
  assign OUT_memAddr = s1_waddr;

  assign push = s2_valid && !s2_kill;
  // A dead or just-killed head is discarded without waiting for writeback.
  assign OUT_valid = !empty && !f_dead[rd_idx] && !head_kill;
  assign pop       = !empty && (IN_wbReady || f_dead[rd_idx] || head_kill);

  assign OUT_result = f_result[rd_idx];
  assign OUT_tagDst = f_tag[rd_idx];
  assign OUT_nmDst  = f_nm[rd_idx];
  assign OUT_sqN    = f_sqn[rd_idx];

  always_comb begin
    bsel    = '0;
    hsel    = '0;
    aligned = IN_memData;
    case (s2_low)
      2'd0:    bsel = IN_memData[7:0];
      2'd1:    bsel = IN_memData[15:8];
      2'd2:    bsel = IN_memData[23:16];
      default: bsel = IN_memData[31:24];
    endcase
    hsel = s2_low[1] ? IN_memData[31:16] : IN_memData[15:0];
    case (s2_size)
      2'd0:    aligned = {{24{s2_sext & bsel[7]}}, bsel};
      2'd1:    aligned = {{16{s2_sext & hsel[15]}}, hsel};
      default: aligned = IN_memData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      f_dead   <= '0;
    end else begin
      s1_valid <= accept && !in_kill;
      s2_valid <= s1_valid && !s1_kill;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (IN_branchTaken && younger(f_sqn[i], IN_branchSqN)) f_dead[i] <= 1'b1;
      end
      if (push) f_dead[wr_idx] <= 1'b0;
    end
  end

  // Payload registers carry no reset; validity lives in the flags above.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_waddr <= IN_addr[31:2];
      s1_low   <= IN_addr[1:0];
      s1_size  <= IN_size;
      s1_sext  <= IN_signExt;
      s1_tag   <= IN_tagDst;
      s1_nm    <= IN_nmDst;
      s1_sqn   <= IN_sqN;
    end
    s2_low  <= s1_low;
    s2_size <= s1_size;
    s2_sext <= s1_sext;
    s2_tag  <= s1_tag;
    s2_nm   <= s1_nm;
    s2_sqn  <= s1_sqn;
    if (push) begin
      f_result[wr_idx] <= aligned;
      f_tag[wr_idx]    <= s2_tag;
      f_nm[wr_idx]     <= s2_nm;
      f_sqn[wr_idx]    <= s2_sqn;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit: alignment, back-pressure,
// flush (including sequence wrap) and mid-operation reset.
module tb_load_align_unit;

  logic        clk, rst;
  logic        IN_valid, IN_ready;
  logic [31:0] IN_addr;
  logic [1:0]  IN_size;
  logic        IN_signExt;
  logic [5:0]  IN_tagDst;
  logic [4:0]  IN_nmDst;
  logic [5:0]  IN_sqN;
  logic        IN_branchTaken;
  logic [5:0]  IN_branchSqN;
  logic        OUT_memEn;
  logic [29:0] OUT_memAddr;
  logic [31:0] IN_memData;
  logic        OUT_valid, IN_wbReady;
  logic [31:0] OUT_result;
  logic [5:0]  OUT_tagDst;
  logic [4:0]  OUT_nmDst;
  logic [5:0]  OUT_sqN;

  int errors = 0;
  int checks = 0;

  load_align_unit #(.DEPTH(4), .SQN_W(6), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .IN_valid(IN_valid), .IN_ready(IN_ready), .IN_addr(IN_addr),
    .IN_size(IN_size), .IN_signExt(IN_signExt), .IN_tagDst(IN_tagDst),
    .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN),
    .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN),
    .OUT_memEn(OUT_memEn), .OUT_memAddr(OUT_memAddr), .IN_memData(IN_memData),
    .OUT_valid(OUT_valid), .IN_wbReady(IN_wbReady), .OUT_result(OUT_result),
    .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_sqN(OUT_sqN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: two fixed words, every other word reads as {2'b10, word address}.
  function automatic logic [31:0] memval(input logic [29:0] w);
    case (w)
      30'h400: return 32'h80ABCD12;
      30'h800: return 32'h80011234;
      default: return {2'b10, w};
    endcase
  endfunction

  always @(posedge clk) IN_memData <= OUT_memEn ? memval(OUT_memAddr) : 32'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                       input logic [5:0] tag, input logic [4:0] nm, input logic [5:0] sq);
    IN_valid = 1'b1; IN_addr = a; IN_size = sz; IN_signExt = sx;
    IN_tagDst = tag; IN_nmDst = nm; IN_sqN = sq;
  endtask

  task automatic idle();
    IN_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] res, input logic [5:0] sq);
    chk({tag, "_valid"}, 32'(OUT_valid), 32'd1);
    chk({tag, "_result"}, OUT_result, res);
    chk({tag, "_sqn"}, 32'(OUT_sqN), 32'(sq));
  endtask

  initial begin
    rst = 1'b1; IN_valid = 1'b0; IN_addr = '0; IN_size = '0; IN_signExt = 1'b0;
    IN_tagDst = '0; IN_nmDst = '0; IN_sqN = '0; IN_branchTaken = 1'b0;
    IN_branchSqN = '0; IN_wbReady = 1'b1;
    step(); step(); #1;
    chk("reset_valid", 32'(OUT_valid), 32'd0);
    chk("reset_memen", 32'(OUT_memEn), 32'd0);
    chk("reset_ready", 32'(IN_ready), 32'd1);

    // Signed byte, lane 3
    step(); rst = 1'b0; issue(32'h1003, 2'd0, 1'b1, 6'd5, 5'd7, 6'd1); #1;
    chk("sbyte_ready", 32'(IN_ready), 32'd1);
    step(); idle(); #1;
    chk("sbyte_memen", 32'(OUT_memEn), 32'd1);
    chk("sbyte_memaddr", 32'(OUT_memAddr), 32'h400);
    step(); #1;
    chk("sbyte_n2_valid", 32'(OUT_valid), 32'd0);
    step(); #1;
    chk_res("sbyte", 32'hFFFFFF80, 6'd1);
    chk("sbyte_tag", 32'(OUT_tagDst), 32'd5);
    chk("sbyte_nm", 32'(OUT_nmDst), 32'd7);
    step(); #1;
    chk("sbyte_popped", 32'(OUT_valid), 32'd0);

    // Back-to-back half/word/byte loads
    step(); issue(32'h2002, 2'd1, 1'b0, 6'd1, 5'd1, 6'd2);
    step(); issue(32'h2002, 2'd1, 1'b1, 6'd2, 5'd2, 6'd3);
    step(); issue(32'h2000, 2'd2, 1'b0, 6'd3, 5'd3, 6'd4);
    step(); issue(32'h1001, 2'd0, 1'b0, 6'd4, 5'd4, 6'd5); #1;
    chk_res("uhalf", 32'h00008001, 6'd2);
    step(); idle(); #1;
    chk_res("shalf", 32'hFFFF8001, 6'd3);
    step(); #1;
    chk_res("word", 32'h80011234, 6'd4);
    step(); #1;
    chk_res("ubyte", 32'h000000CD, 6'd5);
    step(); #1;
    chk("align_drained", 32'(OUT_valid), 32'd0);

    // Back-pressure: five loads, four fit
    step(); IN_wbReady = 1'b0; issue(32'h3000, 2'd2, 1'b0, 6'd10, 5'd1, 6'd10); #1;
    chk("bp_ready0", 32'(IN_ready), 32'd1);
    step(); issue(32'h3004, 2'd2, 1'b0, 6'd11, 5'd1, 6'd11); #1;
    chk("bp_ready1", 32'(IN_ready), 32'd1);
    step(); issue(32'h3008, 2'd2, 1'b0, 6'd12, 5'd1, 6'd12); #1;
    chk("bp_ready2", 32'(IN_ready), 32'd1);
    step(); issue(32'h300C, 2'd2, 1'b0, 6'd13, 5'd1, 6'd13); #1;
    chk("bp_ready3", 32'(IN_ready), 32'd1);
    step(); issue(32'h3010, 2'd2, 1'b0, 6'd14, 5'd1, 6'd14); #1;
    chk("bp_full4", 32'(IN_ready), 32'd0);
    step(); #1;
    chk("bp_full5", 32'(IN_ready), 32'd0);
    step(); #1;
    chk("bp_full6", 32'(IN_ready), 32'd0);
    chk_res("bp_hold", 32'h80000C00, 6'd10);
    step(); IN_wbReady = 1'b1; #1;
    chk_res("bp_r0", 32'h80000C00, 6'd10);
    chk("bp_full7", 32'(IN_ready), 32'd0);
    step(); #1;
    chk("bp_ready_back", 32'(IN_ready), 32'd1);
    chk_res("bp_r1", 32'h80000C01, 6'd11);
    step(); idle(); #1;
    chk_res("bp_r2", 32'h80000C02, 6'd12);
    chk("bp_l4_memen", 32'(OUT_memEn), 32'd1);
    chk("bp_l4_memaddr", 32'(OUT_memAddr), 32'hC04);
    step(); #1;
    chk_res("bp_r3", 32'h80000C03, 6'd13);
    step(); #1;
    chk_res("bp_r4", 32'h80000C04, 6'd14);
    step(); #1;
    chk("bp_empty", 32'(OUT_valid), 32'd0);

    // Push and pop together at full occupancy
    step(); IN_wbReady = 1'b0; issue(32'h3020, 2'd2, 1'b0, 6'd20, 5'd2, 6'd20);
    step(); issue(32'h3024, 2'd2, 1'b0, 6'd21, 5'd2, 6'd21);
    step(); issue(32'h3028, 2'd2, 1'b0, 6'd22, 5'd2, 6'd22);
    step(); issue(32'h302C, 2'd2, 1'b0, 6'd23, 5'd2, 6'd23);
    step(); idle(); #1;
    chk("pp_full", 32'(IN_ready), 32'd0);
    step(); IN_wbReady = 1'b1; #1;
    chk("pp_full_pushpop", 32'(IN_ready), 32'd0);
    chk_res("pp_r0", 32'h80000C08, 6'd20);
    step(); #1;
    chk("pp_ready", 32'(IN_ready), 32'd1);
    chk_res("pp_r1", 32'h80000C09, 6'd21);
    step(); #1;
    chk_res("pp_r2", 32'h80000C0A, 6'd22);
    step(); #1;
    chk_res("pp_r3", 32'h80000C0B, 6'd23);
    step(); #1;
    chk("pp_empty", 32'(OUT_valid), 32'd0);

    // Flush with younger loads in S1 and S2
    step(); IN_wbReady = 1'b0; issue(32'h4000, 2'd2, 1'b0, 6'd3, 5'd3, 6'd3);
    step(); issue(32'h4004, 2'd2, 1'b0, 6'd4, 5'd4, 6'd4);
    step(); issue(32'h4008, 2'd2, 1'b0, 6'd5, 5'd5, 6'd5);
    step(); issue(32'h400C, 2'd2, 1'b0, 6'd6, 5'd6, 6'd6);
    step(); idle(); IN_branchTaken = 1'b1; IN_branchSqN = 6'd4; #1;
    chk("fa_s1_memen", 32'(OUT_memEn), 32'd0);
    chk("fa_head_valid", 32'(OUT_valid), 32'd1);
    step(); IN_branchTaken = 1'b0; IN_wbReady = 1'b1; #1;
    chk("fa_memen_after", 32'(OUT_memEn), 32'd0);
    chk_res("fa_r3", 32'h80001000, 6'd3);
    step(); #1;
    chk_res("fa_r4", 32'h80001001, 6'd4);
    step(); #1;
    chk("fa_no5", 32'(OUT_valid), 32'd0);
    step(); #1;
    chk("fa_no6", 32'(OUT_valid), 32'd0);
    chk("fa_ready", 32'(IN_ready), 32'd1);

    // Wrapped sequence numbers: branch at 62 keeps 61, kills 1 and a same-cycle accept of 2
    step(); IN_wbReady = 1'b0; issue(32'h5000, 2'd2, 1'b0, 6'd61, 5'd9, 6'd61);
    step(); issue(32'h5004, 2'd2, 1'b0, 6'd1, 5'd9, 6'd1);
    step(); idle();
    step();
    step(); issue(32'h5008, 2'd2, 1'b0, 6'd2, 5'd9, 6'd2);
    IN_branchTaken = 1'b1; IN_branchSqN = 6'd62; IN_wbReady = 1'b1; #1;
    chk("fb_ready", 32'(IN_ready), 32'd1);
    chk_res("fb_r61", 32'h80001400, 6'd61);
    step(); idle(); IN_branchTaken = 1'b0; #1;
    chk("fb_killed_head", 32'(OUT_valid), 32'd0);
    chk("fb_accept_killed", 32'(OUT_memEn), 32'd0);
    step(); #1;
    chk("fb_no_result", 32'(OUT_valid), 32'd0);
    chk("fb_ready_after", 32'(IN_ready), 32'd1);

    // Head killed in the same cycle writeback is ready
    step(); IN_wbReady = 1'b0; issue(32'h6000, 2'd2, 1'b0, 6'd10, 5'd1, 6'd10);
    step(); idle();
    step();
    step(); IN_branchTaken = 1'b1; IN_branchSqN = 6'd9; IN_wbReady = 1'b1; #1;
    chk("fc_head_kill", 32'(OUT_valid), 32'd0);
    step(); IN_branchTaken = 1'b0; #1;
    chk("fc_after", 32'(OUT_valid), 32'd0);
    chk("fc_ready", 32'(IN_ready), 32'd1);

    // Reset with three loads outstanding
    step(); IN_wbReady = 1'b0; issue(32'h7000, 2'd2, 1'b0, 6'd30, 5'd1, 6'd30);
    step(); issue(32'h7004, 2'd2, 1'b0, 6'd31, 5'd1, 6'd31);
    step(); issue(32'h7008, 2'd2, 1'b0, 6'd32, 5'd1, 6'd32);
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0; IN_wbReady = 1'b1; #1;
    chk("rst_valid", 32'(OUT_valid), 32'd0);
    chk("rst_memen", 32'(OUT_memEn), 32'd0);
    chk("rst_ready", 32'(IN_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("rst_no_stale", 32'(OUT_valid), 32'd0);
    end
    step(); issue(32'h1002, 2'd0, 1'b1, 6'd8, 5'd8, 6'd40);
    step(); idle();
    step();
    step(); #1;
    chk_res("post_rst_byte", 32'hFFFFFFAB, 6'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
